// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the two-master bus arbiter.
//   HTRANS_*        transfer type encodings
//   HSIZE_WORD      32-bit transfer size
//   HBURST_SINGLE   the only burst type the arbiter issues
//   slot_state_e    per-master slot state (EMPTY / PEND / DATA)
//   is_req()        true for NONSEQ or SEQ; IDLE and BUSY are not requests
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_DATA  = 2'd2
    } slot_state_e;

    // SEQ is accepted as a fresh request (the arbiter issues singles only);
    // BUSY carries no transfer, so it behaves like IDLE.
    function automatic logic is_req(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arb_slot.sv
// ahb_arb_slot: one master's address-phase capture slot.
//   hclk, hrst            clock, asynchronous active-high reset
//   htrans..hmastlock     master address-phase inputs
//   is_owner              this slot owns the slave data phase
//   s_hready              slave ready
//   issue                 arbiter puts this slot onto the slave this edge
//   hready                combinational ready back to the master
//   state                 current slot state (also usable as a debug view)
//   addr..lock            captured address-phase fields
module ahb_arb_slot
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic [1:0]    htrans,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [6:0]    hprot,
    input  logic          hmastlock,
    input  logic          is_owner,
    input  logic          s_hready,
    input  logic          issue,
    output logic          hready,
    output logic [1:0]    state,
    output logic [AW-1:0] addr,
    output logic          write,
    output logic [2:0]    size,
    output logic [6:0]    prot,
    output logic          lock
);

    slot_state_e state_q;
    logic        completing;
    logic        capture;

    assign completing = (state_q == SLOT_DATA) && is_owner && s_hready;
    assign hready     = (state_q == SLOT_EMPTY) || completing;
    assign capture    = hready && is_req(htrans);
    assign state      = state_q;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q <= SLOT_EMPTY;
            addr    <= '0;
            write   <= 1'b0;
            size    <= '0;
            prot    <= '0;
            lock    <= 1'b0;
        end else begin
            if (capture) begin
                addr  <= haddr;
                write <= hwrite;
                size  <= hsize;
                prot  <= hprot;
                lock  <= hmastlock;
            end
            case (state_q)
                SLOT_EMPTY: if (capture) state_q <= SLOT_PEND;
                SLOT_PEND:  if (issue) state_q <= SLOT_DATA;
                // A completing data phase can accept the next address
                // phase on the same edge, giving back-to-back transfers.
                SLOT_DATA:  if (completing) state_q <= capture ? SLOT_PEND : SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-master AHB-Lite arbiter (m0 = IFU, m1 = LSU) onto one
// slave port. Each master's address phase lands in its own slot; pending
// slots are granted onto the slave and the data-phase response is routed
// back to the owning master.
//   hclk, hrst              clock, asynchronous active-high reset
//   m0_* / m1_*             master AHB-Lite ports (hready/hresp/hrdata out)
//   s_*                     slave AHB-Lite port (hready/hresp/hrdata in)
// Handshake: a master address phase is taken on an edge where mk_hready=1
// and mk_htrans requests; the slave takes the issued address phase on an
// edge where s_hready=1, and that edge also ends the previous data phase.
// Build option: AHB_ARB_RR_EN selects round-robin between the two slots;
// without it m1 has fixed priority over m0 and no pointer is built.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [6:0]    m0_hprot,
    input  logic          m0_hmastlock,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    output logic [DW-1:0] m0_hrdata,
    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [6:0]    m1_hprot,
    input  logic          m1_hmastlock,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [DW-1:0] m1_hrdata,
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [6:0]    s_hprot,
    output logic          s_hmastlock,
    output logic [2:0]    s_hburst,
    output logic [DW-1:0] s_hwdata,
    input  logic          s_hready,
    input  logic          s_hresp,
    input  logic [DW-1:0] s_hrdata
);

    logic [1:0]    s0_state, s1_state;
    logic [AW-1:0] s0_addr,  s1_addr;
    logic          s0_write, s1_write;
    logic [2:0]    s0_size,  s1_size;
    logic [6:0]    s0_prot,  s1_prot;
    logic          s0_lock,  s1_lock;

    logic owner_q, lock_q, lock_own_q;
    logic elig0, elig1, sel, sel_valid, sel_lock;
    logic issue, data0, data1, own_release;

    ahb_arb_slot #(.AW(AW)) u_slot0 (
        .hclk(hclk), .hrst(hrst),
        .htrans(m0_htrans), .haddr(m0_haddr), .hwrite(m0_hwrite),
        .hsize(m0_hsize), .hprot(m0_hprot), .hmastlock(m0_hmastlock),
        .is_owner(!owner_q), .s_hready(s_hready), .issue(issue && !sel),
        .hready(m0_hready), .state(s0_state),
        .addr(s0_addr), .write(s0_write), .size(s0_size), .prot(s0_prot), .lock(s0_lock)
    );

    ahb_arb_slot #(.AW(AW)) u_slot1 (
        .hclk(hclk), .hrst(hrst),
        .htrans(m1_htrans), .haddr(m1_haddr), .hwrite(m1_hwrite),
        .hsize(m1_hsize), .hprot(m1_hprot), .hmastlock(m1_hmastlock),
        .is_owner(owner_q), .s_hready(s_hready), .issue(issue && sel),
        .hready(m1_hready), .state(s1_state),
        .addr(s1_addr), .write(s1_write), .size(s1_size), .prot(s1_prot), .lock(s1_lock)
    );

    // While a locked sequence is open only the lock owner may be granted.
    assign elig0     = (s0_state == SLOT_PEND) && (!lock_q || !lock_own_q);
    assign elig1     = (s1_state == SLOT_PEND) && (!lock_q ||  lock_own_q);
    assign sel_valid = elig0 || elig1;
    assign issue     = s_hready && sel_valid;
    assign sel_lock  = sel ? s1_lock : s0_lock;

`ifdef AHB_ARB_RR_EN
    logic rr_last_q;

    always_comb begin
        sel = elig1;
        if (elig0 && elig1) sel = !rr_last_q;
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) rr_last_q <= 1'b0;
        else if (issue) rr_last_q <= sel;
    end
`else
    assign sel = elig1;
`endif

    always_comb begin
        s_haddr     = '0;
        s_hwrite    = 1'b0;
        s_hsize     = '0;
        s_hprot     = '0;
        s_hmastlock = 1'b0;
        if (sel_valid) begin
            if (sel) begin
                s_haddr = s1_addr; s_hwrite = s1_write; s_hsize = s1_size;
                s_hprot = s1_prot; s_hmastlock = s1_lock;
            end else begin
                s_haddr = s0_addr; s_hwrite = s0_write; s_hsize = s0_size;
                s_hprot = s0_prot; s_hmastlock = s0_lock;
            end
        end
    end

    assign s_htrans = sel_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_hburst = HBURST_SINGLE;

    assign data0    = (s0_state == SLOT_DATA);
    assign data1    = (s1_state == SLOT_DATA);
    assign s_hwdata = (data0 || data1) ? (owner_q ? m1_hwdata : m0_hwdata) : '0;
    assign m0_hresp = data0 ? s_hresp : 1'b0;
    assign m1_hresp = data1 ? s_hresp : 1'b0;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // The lock owner ends its locked sequence by going idle with the slot
    // drained and hmastlock dropped.
    always_comb begin
        if (lock_own_q)
            own_release = (s1_state == SLOT_EMPTY) && !is_req(m1_htrans) && !m1_hmastlock;
        else
            own_release = (s0_state == SLOT_EMPTY) && !is_req(m0_htrans) && !m0_hmastlock;
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            if (issue) begin
                owner_q <= sel;
                if (sel_lock) begin
                    lock_q     <= 1'b1;
                    lock_own_q <= sel;
                end else if (sel == lock_own_q) begin
                    lock_q <= 1'b0;
                end
            end else if (lock_q && own_release) begin
                lock_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: vector table plus hand-written reset sequence for the
// two-master AHB-Lite arbiter. Each vector gives one cycle of master/slave
// inputs and the outputs expected during that cycle.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hrst = 1'b1;
    logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
    logic [1:0]    m0_htrans, m1_htrans, s_htrans;
    logic          m0_hwrite, m1_hwrite, s_hwrite;
    logic [2:0]    m0_hsize, m1_hsize, s_hsize, s_hburst;
    logic [6:0]    m0_hprot, m1_hprot, s_hprot;
    logic          m0_hmastlock, m1_hmastlock, s_hmastlock;
    logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata;
    logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [DW-1:0] m0_hrdata, m1_hrdata, s_hrdata;
    logic          s_hready, s_hresp;

    ahb_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .hclk(hclk), .hrst(hrst),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
        .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
        .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
    );

    // ---------------- clock / reset ----------------
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic        m0r, m0l, m1r, m1w, m1l, shr, shrsp;
        logic [31:0] m0a, m1a;
        logic        e0r, e1r, e0p, e1p, ens, ew, el;
        logic [31:0] ea, ed;
    } vec_t;

    typedef struct packed {
        logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
        logic [1:0]    htrans;
        logic [2:0]    hsize;
        logic          hwrite, hmastlock;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwdata, hrdata;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_idx = 0;

    function automatic vec_t v(input int m0r, input int m0a, input int m0l,
                               input int m1r, input int m1a, input int m1w, input int m1l,
                               input int shr, input int shrsp,
                               input int e0r, input int e1r, input int e0p, input int e1p,
                               input int ens, input int ea, input int ew, input int el, input int ed);
        vec_t r;
        r.m0r = m0r[0]; r.m0a = m0a; r.m0l = m0l[0];
        r.m1r = m1r[0]; r.m1a = m1a; r.m1w = m1w[0]; r.m1l = m1l[0];
        r.shr = shr[0]; r.shrsp = shrsp[0];
        r.e0r = e0r[0]; r.e1r = e1r[0]; r.e0p = e0p[0]; r.e1p = e1p[0];
        r.ens = ens[0]; r.ea = ea; r.ew = ew[0]; r.el = el[0]; r.ed = ed;
        return r;
    endfunction

    function automatic logic [1:0] enc(input logic req);
        if (req) return ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        return ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vector %0d): got 0x%0h expected 0x%0h", name, vec_idx, act, exp);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty (vector %0d): got 0 entries expected 1", vec_idx);
            return;
        end
        e = exp_q.pop_front();
        chk("m0_hready",   32'(m0_hready),   32'(e.m0_hready));
        chk("m1_hready",   32'(m1_hready),   32'(e.m1_hready));
        chk("m0_hresp",    32'(m0_hresp),    32'(e.m0_hresp));
        chk("m1_hresp",    32'(m1_hresp),    32'(e.m1_hresp));
        chk("s_htrans",    32'(s_htrans),    32'(e.htrans));
        chk("s_hsize",     32'(s_hsize),     32'(e.hsize));
        chk("s_hwrite",    32'(s_hwrite),    32'(e.hwrite));
        chk("s_hmastlock", 32'(s_hmastlock), 32'(e.hmastlock));
        chk("s_haddr",     s_haddr,          e.haddr);
        chk("s_hwdata",    s_hwdata,         e.hwdata);
        chk("m0_hrdata",   m0_hrdata,        e.hrdata);
        chk("m1_hrdata",   m1_hrdata,        e.hrdata);
        chk("s_hburst",    32'(s_hburst),    32'(HBURST_SINGLE));
    endtask

    // ---------------- driver ----------------
    task automatic apply_vec(input vec_t x);
        exp_t e;
        logic [31:0] rd;
        @(posedge hclk);
        #1;
        rd           = $urandom;
        m0_htrans    = enc(x.m0r);
        m0_haddr     = x.m0a;
        m0_hmastlock = x.m0l;
        m1_htrans    = enc(x.m1r);
        m1_haddr     = x.m1a;
        m1_hwrite    = x.m1w;
        m1_hmastlock = x.m1l;
        s_hready     = x.shr;
        s_hresp      = x.shrsp;
        s_hrdata     = rd;
        e.m0_hready  = x.e0r;
        e.m1_hready  = x.e1r;
        e.m0_hresp   = x.e0p;
        e.m1_hresp   = x.e1p;
        e.htrans     = x.ens ? HTRANS_NONSEQ : HTRANS_IDLE;
        e.hsize      = x.ens ? HSIZE_WORD : 3'b000;
        e.hwrite     = x.ew;
        e.hmastlock  = x.el;
        e.haddr      = x.ea;
        e.hwdata     = x.ed;
        e.hrdata     = rd;
        exp_q.push_back(e);
        @(negedge hclk);
        compare_outputs();
    endtask

    // ---------------- test ----------------
    initial begin
        m0_haddr = '0; m0_htrans = HTRANS_IDLE; m0_hwrite = 1'b0; m0_hsize = HSIZE_WORD;
        m0_hprot = 7'h03; m0_hmastlock = 1'b0; m0_hwdata = 32'h66;
        m1_haddr = '0; m1_htrans = HTRANS_IDLE; m1_hwrite = 1'b0; m1_hsize = HSIZE_WORD;
        m1_hprot = 7'h03; m1_hmastlock = 1'b0; m1_hwdata = 32'h55;
        s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;

        // Columns: m0 req,addr,lock | m1 req,addr,write,lock | s_hready,s_hresp |
        //          exp m0_hready,m1_hready,m0_hresp,m1_hresp | nonseq,haddr,hwrite,hmastlock,hwdata
        // Single m0 read: one wait state, slave sees it one cycle after acceptance.
        vecs.push_back(v(1,'h100,0, 0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,0, 0,1,0,0, 1,'h100,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,'h66));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        // Simultaneous m0 read 0x200 / m1 write 0x300: m1 first, m0 stalls an extra cycle.
        vecs.push_back(v(1,'h200,0, 1,'h300,1,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'h300,1,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'h200,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
        // Two slave wait states on m1 read while m0 pends.
        vecs.push_back(v(1,'h400,0, 1,'h500,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'h500,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     0,0, 0,0,0,0, 1,'h400,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     0,0, 0,0,0,0, 1,'h400,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'h400,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
        // Two-cycle ERROR to m0.
        vecs.push_back(v(1,'h600,0, 0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,0, 0,1,0,0, 1,'h600,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0, 0,1, 0,1,1,0, 0,0,0,0,'h66));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,1, 1,1,1,0, 0,0,0,0,'h66));
        vecs.push_back(v(0,0,0,     0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        // Locked m1 sequence holds m0 off until m1 issues an unlocked transfer.
        vecs.push_back(v(0,0,0,     1,'h700,0,1, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(1,'h800,0, 0,0,0,1,     1,0, 1,0,0,0, 1,'h700,0,1,0));
        vecs.push_back(v(0,0,0,     1,'h704,0,1, 1,0, 0,1,0,0, 0,0,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,1,     1,0, 0,0,0,0, 1,'h704,0,1,0));
        vecs.push_back(v(0,0,0,     1,'h708,0,0, 1,0, 0,1,0,0, 0,0,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'h708,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'h800,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
        // Lock released by the owner going idle with hmastlock low.
        vecs.push_back(v(0,0,0,     1,'h900,0,1, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,1,     1,0, 1,0,0,0, 1,'h900,0,1,0));
        vecs.push_back(v(1,'hA00,0, 0,0,0,1,     1,0, 1,1,0,0, 0,0,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,1,     1,0, 0,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'hA00,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
        // Both masters requesting continuously: slave order m1, m0, m1, m0.
        vecs.push_back(v(1,'hB00,0, 1,'hC00,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(1,'hB00,0, 1,'hC00,0,0, 1,0, 0,0,0,0, 1,'hC00,0,0,0));
        vecs.push_back(v(1,'hB00,0, 1,'hC00,0,0, 1,0, 0,1,0,0, 1,'hB00,0,0,'h55));
        vecs.push_back(v(1,'hB00,0, 1,'hC00,0,0, 1,0, 1,0,0,0, 1,'hC00,0,0,'h66));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'hB00,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
        // Tie right after an m1 issue: round-robin favours m0, fixed priority m1.
        vecs.push_back(v(0,0,0,     1,'hD00,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,0,0,0, 1,'hD00,0,0,0));
        vecs.push_back(v(1,'hE00,0, 1,'hD04,0,0, 1,0, 1,1,0,0, 0,0,0,0,'h55));
`ifdef AHB_ARB_RR_EN
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'hE00,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,0,0,0, 1,'hD04,0,0,'h66));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h55));
`else
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'hD04,0,0,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 0,1,0,0, 1,'hE00,0,0,'h55));
        vecs.push_back(v(0,0,0,     0,0,0,0,     1,0, 1,1,0,0, 0,0,0,0,'h66));
`endif

        // Reset state while hrst is held.
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("rst_m0_hready", 32'(m0_hready), 32'd1);
        chk("rst_m1_hready", 32'(m1_hready), 32'd1);
        chk("rst_m0_hresp",  32'(m0_hresp),  32'd0);
        chk("rst_s_htrans",  32'(s_htrans),  32'(HTRANS_IDLE));
        chk("rst_s_haddr",   s_haddr,        32'd0);
        chk("rst_s_hwdata",  s_hwdata,       32'd0);
        hrst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_idx = i;
            apply_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of an m1 data phase with m0 pending.
        vec_idx = 1000;
        apply_vec(v(1,'hF00,0, 1,'hF80,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        apply_vec(v(0,0,0,     0,0,0,0,     1,0, 0,0,0,0, 1,'hF80,0,0,0));
        apply_vec(v(0,0,0,     0,0,0,0,     0,1, 0,0,0,1, 1,'hF00,0,0,'h55));
        #1 hrst = 1'b1;
        #1;
        chk("midrst_m0_hready", 32'(m0_hready), 32'd1);
        chk("midrst_m1_hready", 32'(m1_hready), 32'd1);
        chk("midrst_m1_hresp",  32'(m1_hresp),  32'd0);
        chk("midrst_s_htrans",  32'(s_htrans),  32'(HTRANS_IDLE));
        chk("midrst_s_haddr",   s_haddr,        32'd0);
        chk("midrst_s_hwdata",  s_hwdata,       32'd0);
        @(posedge hclk);
        @(negedge hclk);
        hrst = 1'b0;

        // Recovery: a fresh m0 read behaves exactly as from power-on.
        vec_idx = 2000;
        apply_vec(v(0,0,0,     0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        apply_vec(v(1,'h104,0, 0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,0));
        apply_vec(v(0,0,0,     0,0,0,0, 1,0, 0,1,0,0, 1,'h104,0,0,0));
        apply_vec(v(0,0,0,     0,0,0,0, 1,0, 1,1,0,0, 0,0,0,0,'h66));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
